mem_demux: RTL and testbench
============================

# mem_demux

Routes a single CPU load/store request to one of two targets: data memory (target 0) or the memory-mapped I/O block (target 1). It returns read data from the selected target to the CPU. It sits between the datapath's memory stage and the two memory targets, and it is the distribution counterpart of the datapath's 2:1 select muxes. A registered request latch, a 3-state FSM and a read-timeout counter make every transaction a single outstanding, fully handshaked operation.

## Interface
- DATA_WIDTH, 32, width of write and read data.
- ADDR_WIDTH, 32, width of the address.
- IO_BASE, 32'hFFFF_0000, first address mapped to target 1. Addresses below IO_BASE go to target 0.
- TIMEOUT, 16, maximum cycles spent waiting for read data (must be ≥ 2).
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  CPU request valid.
- REQ_READY  out  1  block can accept a request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  ADDR_WIDTH  request address.
- REQ_WDATA  in  DATA_WIDTH  store data.
- RSP_VALID  out  1  one-cycle load-completion pulse.
- RSP_RDATA  out  DATA_WIDTH  load data.
- RSP_ERR  out  1  load timed out (qualified by RSP_VALID).
- Tk_VALID  out  1  request to target k (k = 0, 1).
- Tk_READY  in  1  target k accepts the request.
- Tk_WE  out  1  store strobe to target k.
- Tk_ADDR  out  ADDR_WIDTH  address to target k.
- Tk_WDATA  out  DATA_WIDTH  store data to target k.
- Tk_RVALID  in  1  target k read data valid.
- Tk_RDATA  in  DATA_WIDTH  target k read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE.
- REQ_READY = (state == IDLE). This signal is combinational from the state register only.
- IDLE:
  - On REQ_VALID, latch WE, ADDR and WDATA.
  - Compute SEL = (REQ_ADDR >= IO_BASE), using an unsigned compare.
  - Go to ISSUE.
- ISSUE:
  - T[SEL]_VALID = 1; the other target's VALID = 0.
  - Both Tk_ADDR and Tk_WDATA carry the latched values.
  - Tk_WE = latched WE only when k == SEL; otherwise 0.
  - Hold ISSUE while T[SEL]_READY = 0. There is no timeout in ISSUE.
  - On T[SEL]_READY = 1 with a store: go to IDLE. No response is generated.
  - On T[SEL]_READY = 1 with a load: clear the counter and go to WAIT.
- WAIT:
  - Only T[SEL]_RVALID is observed. The non-selected RVALID/RDATA are ignored.
  - On T[SEL]_RVALID: register RSP_RDATA = T[SEL]_RDATA, RSP_ERR = 0, RSP_VALID = 1, then go to IDLE.
  - Otherwise, if counter == TIMEOUT-1: register RSP_RDATA = 0, RSP_ERR = 1, RSP_VALID = 1, then go to IDLE.
  - Otherwise, increment the counter.
  - RVALID in the final permitted cycle wins over the timeout.
- RSP_VALID is high for exactly one cycle per load. It is never asserted for stores.
- RSP_RDATA and RSP_ERR hold their values until the next load completes.
- A new request may be accepted in the same cycle that RSP_VALID is high, because the FSM is already in IDLE.
- Counter width is clog2(TIMEOUT). It is only active in WAIT.
- Reset values: state IDLE, latches 0, counter 0, RSP_VALID 0, RSP_RDATA 0, RSP_ERR 0.
- Reset values of the target outputs: T0_VALID and T1_VALID are 0, T0_WE and T1_WE are 0.

## Timing
- Request accepted at edge N (REQ_VALID && REQ_READY), so Tk_VALID is high in cycle N+1.
- Store with immediate READY: target handshake at edge N+1, and REQ_READY is high again in cycle N+2.
- Load with immediate READY and RVALID in the first WAIT cycle (N+2): RSP_VALID is high in cycle N+3. This is the minimum load latency of 3 cycles.
- The maximum cycles in WAIT is TIMEOUT. On timeout, RSP_VALID rises in the cycle after the TIMEOUT-th WAIT cycle.
- All outputs except REQ_READY are registered.
- RST sampled high at any edge, in any state, forces all reset values at that edge. The in-flight transaction is abandoned.
- An RVALID that arrives later, while the block is in IDLE, is ignored.

## Test plan
- Reset: hold RST for 2 cycles mid-stream → REQ_READY = 1, T0_VALID = T1_VALID = 0, RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 0.
- Store 0xDEADBEEF to 0x0000_0040 with T0_READY = 1 → T0_VALID/T0_WE high for exactly one cycle with those values, T1_VALID stays 0, no RSP_VALID, REQ_READY is back 2 cycles after accept.
- Load from 0xFFFF_0004 with T1_READY low for 3 cycles then high, and T1_RVALID 2 cycles later carrying 0x1234_5678 → a single RSP_VALID pulse with RSP_RDATA = 0x1234_5678, RSP_ERR = 0.
- Load from 0x0000_0100 with T0_RVALID never asserted (TIMEOUT = 16) → exactly 16 WAIT cycles, then RSP_VALID = 1, RSP_ERR = 1, RSP_RDATA = 0.
- Address boundary and spurious responses:
  - Load from 0xFFFE_FFFF routes to T0; load from 0xFFFF_0000 routes to T1.
  - A T1_RVALID pulse during a T0 load wait is ignored.
  - T0_RVALID on WAIT cycle 16 yields valid data with RSP_ERR = 0.
- RST asserted during WAIT, then T0_RVALID two cycles later → the block is in IDLE after the reset edge, and RSP_VALID never rises.

Source files
------------

// File: rtl/mem_demux.sv
// Routes one CPU load/store at a time to data memory (target 0) or MMIO (target 1) and
// returns load data or a timeout error. All outputs except req_ready_o are registered.
module mem_demux #(
  parameter int unsigned               DataWidth = 32,
  parameter int unsigned               AddrWidth = 32,
  parameter logic [AddrWidth-1:0]      IoBase    = 32'hFFFF_0000,
  parameter int unsigned               Timeout   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 t0_valid_o,
  input  logic                 t0_ready_i,
  output logic                 t0_we_o,
  output logic [AddrWidth-1:0] t0_addr_o,
  output logic [DataWidth-1:0] t0_wdata_o,
  input  logic                 t0_rvalid_i,
  input  logic [DataWidth-1:0] t0_rdata_i,
  output logic                 t1_valid_o,
  input  logic                 t1_ready_i,
  output logic                 t1_we_o,
  output logic [AddrWidth-1:0] t1_addr_o,
  output logic [DataWidth-1:0] t1_wdata_o,
  input  logic                 t1_rvalid_i,
  input  logic [DataWidth-1:0] t1_rdata_i
);

  localparam int unsigned CntW = $clog2(Timeout);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 sel_q, sel_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           tvalid_q, tvalid_d;
  logic [1:0]           twe_q, twe_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  // Only the selected target's handshake and read-data signals are observed.
  logic                 sel_ready;
  logic                 sel_rvalid;
  logic [DataWidth-1:0] sel_rdata;

  assign sel_ready  = sel_q ? t1_ready_i  : t0_ready_i;
  assign sel_rvalid = sel_q ? t1_rvalid_i : t0_rvalid_i;
  assign sel_rdata  = sel_q ? t1_rdata_i  : t0_rdata_i;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    tvalid_d    = tvalid_q;
    twe_d       = twe_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d     = req_we_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          sel_d    = (req_addr_i >= IoBase);
          tvalid_d = sel_d ? 2'b10 : 2'b01;
          twe_d    = req_we_i ? tvalid_d : 2'b00;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (sel_ready) begin
          tvalid_d = 2'b00;
          twe_d    = 2'b00;
          if (we_q) begin
            state_d = StIdle;
          end else begin
            cnt_d   = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Read data in the last permitted cycle takes priority over the timeout.
        if (sel_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = sel_rdata;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
        end else if (cnt_q == CntW'(Timeout - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      tvalid_q    <= 2'b00;
      twe_q       <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      tvalid_q    <= tvalid_d;
      twe_q       <= twe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  assign t0_valid_o  = tvalid_q[0];
  assign t0_we_o     = twe_q[0];
  assign t0_addr_o   = addr_q;
  assign t0_wdata_o  = wdata_q;
  assign t1_valid_o  = tvalid_q[1];
  assign t1_we_o     = twe_q[1];
  assign t1_addr_o   = addr_q;
  assign t1_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mem_demux.sv
// Self-checking bench for mem_demux: directed vector table, random transactions against a
// transaction-level model, and a reset-during-wait sequence.
module tb_mem_demux;

  localparam int unsigned  TO     = 16;
  localparam logic [31:0]  IoBase = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        t0_valid, t1_valid, t0_we, t1_we;
  logic [31:0] t0_addr, t1_addr, t0_wdata, t1_wdata;
  logic [1:0]  t_ready, t_rvalid;
  logic [31:0] t_rdata [2];
  logic [1:0]  t_valid, t_we;

  assign t_valid = {t1_valid, t0_valid};
  assign t_we    = {t1_we, t0_we};

  always #5 clk = ~clk;

  mem_demux #(
    .DataWidth (32),
    .AddrWidth (32),
    .IoBase    (IoBase),
    .Timeout   (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .t0_valid_o  (t0_valid),
    .t0_ready_i  (t_ready[0]),
    .t0_we_o     (t0_we),
    .t0_addr_o   (t0_addr),
    .t0_wdata_o  (t0_wdata),
    .t0_rvalid_i (t_rvalid[0]),
    .t0_rdata_i  (t_rdata[0]),
    .t1_valid_o  (t1_valid),
    .t1_ready_i  (t_ready[1]),
    .t1_we_o     (t1_we),
    .t1_addr_o   (t1_addr),
    .t1_wdata_o  (t1_wdata),
    .t1_rvalid_i (t_rvalid[1]),
    .t1_rdata_i  (t_rdata[1])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdly;     // ISSUE cycles with target ready low
    int          vdly;     // WAIT cycle index where rvalid arrives (>= TO: never)
    logic [31:0] rdata;
    bit          spur;     // pulse the other target's rvalid during WAIT
    logic        exp_sel;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level expectations from the routing and timeout rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_sel  = (v.addr >= IoBase);
    r.exp_err  = (v.vdly >= int'(TO));
    r.exp_data = r.exp_err ? 32'h0 : v.rdata;
    return r;
  endfunction

  // Starts and ends on a falling edge with the DUT idle.
  task automatic run_txn(input vec_t v);
    int s = v.exp_sel ? 1 : 0;
    int o = 1 - s;
    int last;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int c = 0; c <= v.rdly; c++) begin
      chk("issue_valid", 32'(t_valid), v.exp_sel ? 32'd2 : 32'd1);
      chk("issue_we", 32'(t_we), v.we ? (v.exp_sel ? 32'd2 : 32'd1) : 32'd0);
      chk("issue_addr0", t0_addr, v.addr);
      chk("issue_addr1", t1_addr, v.addr);
      chk("issue_wdata", v.exp_sel ? t1_wdata : t0_wdata, v.wdata);
      chk("issue_busy", 32'(req_ready), 32'd0);
      t_ready[s] = (c == v.rdly);
      t_ready[o] = 1'b1;
      @(negedge clk);
    end
    t_ready = 2'b00;
    chk("post_issue_valid", 32'(t_valid), 32'd0);
    if (v.we) begin
      chk("store_ready_back", 32'(req_ready), 32'd1);
      chk("store_no_rsp", 32'(rsp_valid), 32'd0);
      return;
    end
    last = (v.vdly < int'(TO)) ? v.vdly : int'(TO) - 1;
    for (int w = 0; w <= last; w++) begin
      chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
      chk("wait_busy", 32'(req_ready), 32'd0);
      t_rvalid[s] = (w == v.vdly);
      t_rdata[s]  = (w == v.vdly) ? v.rdata : $urandom;
      t_rvalid[o] = v.spur;
      t_rdata[o]  = $urandom;
      @(negedge clk);
    end
    t_rvalid = 2'b00;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("rsp_rdata", rsp_rdata, v.exp_data);
    chk("rsp_ready_same_cycle", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("rsp_rdata_hold", rsp_rdata, v.exp_data);
    chk("rsp_err_hold", 32'(rsp_err), 32'(v.exp_err));
  endtask

  task automatic chk_reset_state();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_t_valid", 32'(t_valid), 32'd0);
    chk("rst_t_we", 32'(t_we), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    t_ready    = 2'b00;
    t_rvalid   = 2'b00;
    t_rdata[0] = '0;
    t_rdata[1] = '0;

    //           we    addr          wdata         rd vd  rdata         sp  sel   err   data
    vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 32'h0,        0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'hFFFF_0004, 32'h0,         3, 1, 32'h1234_5678, 0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0,         0, 99, 32'h9999_9999, 0, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'hFFFE_FFFF, 32'h0,         0, 0, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[4] = '{1'b0, 32'hFFFF_0000, 32'h0,         1, 0, 32'h5A5A_0002, 0, 1'b1, 1'b0, 32'h5A5A_0002};
    vecs[5] = '{1'b0, 32'h0000_0200, 32'h0,         0, 5, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 32'h0BAD_F00D};
    vecs[6] = '{1'b0, 32'h0000_0300, 32'h0,         0, 15, 32'h1600_0016, 0, 1'b0, 1'b0, 32'h1600_0016};
    vecs[7] = '{1'b1, 32'hFFFF_0010, 32'h0000_0077, 2, 0, 32'h0,        0, 1'b1, 1'b0, 32'h0};

    @(negedge clk);
    @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v.addr = $urandom;
        1:       v.addr = IoBase - 32'($urandom_range(1, 4));
        2:       v.addr = IoBase + 32'($urandom_range(0, 4));
        default: v.addr = 32'($urandom_range(0, 32'hFFFF));
      endcase
      v.wdata = $urandom;
      v.rdly  = int'($urandom_range(0, 3));
      v.vdly  = int'($urandom_range(0, TO + 2));
      v.rdata = $urandom;
      v.spur  = 1'($urandom_range(0, 1));
      run_txn(model(v));
    end

    // Reset mid-WAIT: a late rvalid after reset must not produce a response.
    run_txn('{1'b0, 32'h0000_0080, 32'h0, 0, 0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 32'hCAFE_F00D});
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0100;
    @(negedge clk);
    req_valid  = 1'b0;
    t_ready[0] = 1'b1;
    @(negedge clk);
    t_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    @(negedge clk);
    rst         = 1'b0;
    t_rvalid[0] = 1'b1;
    t_rdata[0]  = 32'h5555_AAAA;
    @(negedge clk);
    t_rvalid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("late_rvalid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("late_rvalid_idle", 32'(req_ready), 32'd1);
      chk("late_rvalid_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
    end
    run_txn('{1'b1, 32'h0000_0010, 32'h0000_1111, 1, 0, 32'h0, 0, 1'b0, 1'b0, 32'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
